// File: rtl/mem_arbiter.sv
// Round-robin arbiter multiplexing per-thread LSU loads/stores onto one shared memory channel.
// One transaction is in flight at a time; results are relayed back until the requester lets go.
module mem_arbiter #(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8
) (
    input  logic                               clk,
    input  logic                               reset,

    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,

    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,

    output logic                               mem_read_valid,
    output logic [ADDR_BITS-1:0]               mem_read_address,
    input  logic                               mem_read_ready,
    input  logic [DATA_BITS-1:0]               mem_read_data,

    output logic                               mem_write_valid,
    output logic [ADDR_BITS-1:0]               mem_write_address,
    output logic [DATA_BITS-1:0]               mem_write_data,
    input  logic                               mem_write_ready,

    output logic                               busy
);

    localparam int PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StReadWait,
        StWriteWait,
        StRelay
    } state_e;

    state_e                             r_state, w_state_nxt;
    logic [PTR_W-1:0]                   r_rr_ptr, w_rr_ptr_nxt;
    logic [PTR_W-1:0]                   r_grant, w_grant_nxt;
    logic                               r_is_read, w_is_read_nxt;
    logic                               r_mem_read_valid, w_mem_read_valid_nxt;
    logic [ADDR_BITS-1:0]               r_mem_read_address, w_mem_read_address_nxt;
    logic                               r_mem_write_valid, w_mem_write_valid_nxt;
    logic [ADDR_BITS-1:0]               r_mem_write_address, w_mem_write_address_nxt;
    logic [DATA_BITS-1:0]               r_mem_write_data, w_mem_write_data_nxt;
    logic [NUM_CONSUMERS-1:0]           r_read_ready, w_read_ready_nxt;
    logic [NUM_CONSUMERS-1:0]           r_write_ready, w_write_ready_nxt;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] r_read_data, w_read_data_nxt;

    logic                               w_found;
    logic [PTR_W-1:0]                   w_sel;
    logic [PTR_W-1:0]                   w_scan_idx;
    logic [ADDR_BITS-1:0]               w_sel_raddr;
    logic [ADDR_BITS-1:0]               w_sel_waddr;
    logic [DATA_BITS-1:0]               w_sel_wdata;
    logic                               w_relay_done;

    // Scan starting at the round-robin pointer; first requester (read or write) wins.
    always_comb begin
        w_found    = 1'b0;
        w_sel      = '0;
        w_scan_idx = '0;
        for (int off = 0; off < NUM_CONSUMERS; off++) begin
            w_scan_idx = PTR_W'((int'(r_rr_ptr) + off) % NUM_CONSUMERS);
            if (!w_found &&
                (consumer_read_valid[w_scan_idx] || consumer_write_valid[w_scan_idx])) begin
                w_found = 1'b1;
                w_sel   = w_scan_idx;
            end
        end
    end

    always_comb begin
        w_sel_raddr = '0;
        w_sel_waddr = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            if (PTR_W'(i) == w_sel) begin
                w_sel_raddr = consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
                w_sel_waddr = consumer_write_address[i*ADDR_BITS +: ADDR_BITS];
                w_sel_wdata = consumer_write_data[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    assign w_relay_done = r_is_read ? !consumer_read_valid[r_grant]
                                    : !consumer_write_valid[r_grant];

    always_comb begin
        w_state_nxt             = r_state;
        w_rr_ptr_nxt            = r_rr_ptr;
        w_grant_nxt             = r_grant;
        w_is_read_nxt           = r_is_read;
        w_mem_read_valid_nxt    = r_mem_read_valid;
        w_mem_read_address_nxt  = r_mem_read_address;
        w_mem_write_valid_nxt   = r_mem_write_valid;
        w_mem_write_address_nxt = r_mem_write_address;
        w_mem_write_data_nxt    = r_mem_write_data;
        w_read_ready_nxt        = r_read_ready;
        w_write_ready_nxt       = r_write_ready;
        w_read_data_nxt         = r_read_data;

        unique case (r_state)
            StIdle: begin
                if (w_found) begin
                    w_grant_nxt = w_sel;
                    // A consumer asking for both is served its load first.
                    if (consumer_read_valid[w_sel]) begin
                        w_is_read_nxt          = 1'b1;
                        w_mem_read_valid_nxt   = 1'b1;
                        w_mem_read_address_nxt = w_sel_raddr;
                        w_state_nxt            = StReadWait;
                    end else begin
                        w_is_read_nxt           = 1'b0;
                        w_mem_write_valid_nxt   = 1'b1;
                        w_mem_write_address_nxt = w_sel_waddr;
                        w_mem_write_data_nxt    = w_sel_wdata;
                        w_state_nxt             = StWriteWait;
                    end
                end
            end
            StReadWait: begin
                if (mem_read_ready) begin
                    w_mem_read_valid_nxt = 1'b0;
                    for (int i = 0; i < NUM_CONSUMERS; i++) begin
                        if (PTR_W'(i) == r_grant) begin
                            w_read_data_nxt[i*DATA_BITS +: DATA_BITS] = mem_read_data;
                            w_read_ready_nxt[i]                       = 1'b1;
                        end
                    end
                    w_state_nxt = StRelay;
                end
            end
            StWriteWait: begin
                if (mem_write_ready) begin
                    w_mem_write_valid_nxt = 1'b0;
                    for (int i = 0; i < NUM_CONSUMERS; i++) begin
                        if (PTR_W'(i) == r_grant) begin
                            w_write_ready_nxt[i] = 1'b1;
                        end
                    end
                    w_state_nxt = StRelay;
                end
            end
            StRelay: begin
                if (w_relay_done) begin
                    w_read_ready_nxt  = '0;
                    w_write_ready_nxt = '0;
                    w_rr_ptr_nxt      = (r_grant == PTR_W'(NUM_CONSUMERS - 1)) ? '0
                                                                               : r_grant + 1'b1;
                    w_state_nxt       = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state             <= StIdle;
            r_rr_ptr            <= '0;
            r_grant             <= '0;
            r_is_read           <= 1'b0;
            r_mem_read_valid    <= 1'b0;
            r_mem_read_address  <= '0;
            r_mem_write_valid   <= 1'b0;
            r_mem_write_address <= '0;
            r_mem_write_data    <= '0;
            r_read_ready        <= '0;
            r_write_ready       <= '0;
            r_read_data         <= '0;
        end else begin
            r_state             <= w_state_nxt;
            r_rr_ptr            <= w_rr_ptr_nxt;
            r_grant             <= w_grant_nxt;
            r_is_read           <= w_is_read_nxt;
            r_mem_read_valid    <= w_mem_read_valid_nxt;
            r_mem_read_address  <= w_mem_read_address_nxt;
            r_mem_write_valid   <= w_mem_write_valid_nxt;
            r_mem_write_address <= w_mem_write_address_nxt;
            r_mem_write_data    <= w_mem_write_data_nxt;
            r_read_ready        <= w_read_ready_nxt;
            r_write_ready       <= w_write_ready_nxt;
            r_read_data         <= w_read_data_nxt;
        end
    end

    assign consumer_read_ready  = r_read_ready;
    assign consumer_read_data   = r_read_data;
    assign consumer_write_ready = r_write_ready;
    assign mem_read_valid       = r_mem_read_valid;
    assign mem_read_address     = r_mem_read_address;
    assign mem_write_valid      = r_mem_write_valid;
    assign mem_write_address    = r_mem_write_address;
    assign mem_write_data       = r_mem_write_data;
    assign busy                 = (r_state != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts grant order and data,
// a monitor process pops and compares as the DUT presents memory requests and consumer readies.
module tb_mem_arbiter;

    localparam int N = 4;
    localparam int A = 8;
    localparam int D = 8;

    typedef struct {
        bit             wr;
        int             c;
        logic [A-1:0]   addr;
        logic [D-1:0]   data;
    } txn_t;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   rv = '0, wv = '0;
    logic [N*A-1:0] ra = '0, wa = '0;
    logic [N*D-1:0] wd = '0;
    logic [N-1:0]   crr, cwr;
    logic [N*D-1:0] crd;
    logic           mrv, mwv, mrr, mwr, busy;
    logic [A-1:0]   mra, mwa;
    logic [D-1:0]   mrd = '0, mwd;
    logic           resp_rr = 1'b0, resp_wr = 1'b0, spur = 1'b0;

    assign mrr = resp_rr | spur;
    assign mwr = resp_wr | spur;

    always #5 clk = ~clk;

    mem_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(A), .DATA_BITS(D)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (rv),
        .consumer_read_address  (ra),
        .consumer_read_ready    (crr),
        .consumer_read_data     (crd),
        .consumer_write_valid   (wv),
        .consumer_write_address (wa),
        .consumer_write_data    (wd),
        .consumer_write_ready   (cwr),
        .mem_read_valid         (mrv),
        .mem_read_address       (mra),
        .mem_read_ready         (mrr),
        .mem_read_data          (mrd),
        .mem_write_valid        (mwv),
        .mem_write_address      (mwa),
        .mem_write_data         (mwd),
        .mem_write_ready        (mwr),
        .busy                   (busy)
    );

    int n_total = 0;
    int n_bad   = 0;

    txn_t         exp_q[$];
    int           m_rr = 0;
    logic [D-1:0] ref_mem[256];
    logic [D-1:0] resp_mem[256];
    logic [D-1:0] ref_rdata[N];
    logic [A-1:0] req_ra[N], req_wa[N];
    logic [D-1:0] req_wd[N];
    bit           mon_en = 1'b1;
    bit           resp_hold = 1'b0;
    int           resp_fix = -1;
    int           rs = 0, rcnt = 0;
    bit           rwr = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // One cycle: consumers drop valid on seeing ready; memory model answers after a delay.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (crr[i]) rv[i] = 1'b0;
            if (cwr[i]) wv[i] = 1'b0;
        end
        if (rs == 0 && !resp_hold && (mrv || mwv)) begin
            rwr  = mwv;
            rcnt = (resp_fix >= 0) ? resp_fix : int'($urandom_range(0, 3));
            rs   = 1;
        end else if (rs == 2) begin
            resp_rr = 1'b0;
            resp_wr = 1'b0;
            mrd     = D'($urandom);
            check(rwr ? "wr_ready_latency" : "rd_ready_latency", rwr ? |cwr : |crr, 1);
            check("mem_valid_cleared", rwr ? mwv : mrv, 0);
            rs = 0;
        end
        if (rs == 1) begin
            if (rcnt == 0) begin
                if (rwr) begin
                    resp_mem[mwa] = mwd;
                    resp_wr       = 1'b1;
                end else begin
                    mrd     = resp_mem[mra];
                    resp_rr = 1'b1;
                end
                rs = 2;
            end else begin
                rcnt--;
            end
        end
    endtask

    // Present a batch of requests at once and predict the complete service order.
    task automatic issue(input logic [N-1:0] rmask, input logic [N-1:0] wmask);
        logic [N-1:0] pr, pw;
        int           idx;
        txn_t         t;
        for (int i = 0; i < N; i++) begin
            ra[i*A +: A] = req_ra[i];
            wa[i*A +: A] = req_wa[i];
            wd[i*D +: D] = req_wd[i];
        end
        rv = rmask;
        wv = wmask;
        pr = rmask;
        pw = wmask;
        while ((pr | pw) != '0) begin
            idx = 0;
            for (int off = 0; off < N; off++) begin
                idx = (m_rr + off) % N;
                if (pr[idx] || pw[idx]) break;
            end
            t.c = idx;
            if (pr[idx]) begin
                t.wr           = 1'b0;
                t.addr         = req_ra[idx];
                t.data         = ref_mem[t.addr];
                ref_rdata[idx] = t.data;
                pr[idx]        = 1'b0;
            end else begin
                t.wr            = 1'b1;
                t.addr          = req_wa[idx];
                t.data          = req_wd[idx];
                ref_mem[t.addr] = t.data;
                pw[idx]         = 1'b0;
            end
            exp_q.push_back(t);
            m_rr = (idx + 1) % N;
        end
    endtask

    task automatic wait_idle(input string name);
        int cyc = 0;
        while (!(exp_q.size() == 0 && rv == '0 && wv == '0 && !busy) && cyc < 400) begin
            tick();
            cyc++;
        end
        if (cyc >= 400) begin
            n_total++;
            n_bad++;
            $display("FAIL %s timeout: pending=%0d busy=%0b required idle", name, exp_q.size(), busy);
            exp_q.delete();
            rv = '0;
            wv = '0;
        end
        for (int i = 0; i < N; i++) check("rd_data_retained", crd[i*D +: D], ref_rdata[i]);
    endtask

    task automatic rand_reqs();
        for (int i = 0; i < N; i++) begin
            req_ra[i] = A'($urandom_range(0, 15));
            req_wa[i] = A'($urandom_range(0, 15));
            req_wd[i] = D'($urandom);
        end
    endtask

    // Monitor: pops the predicted transaction whenever the DUT opens a memory request.
    initial begin : monitor
        logic         p_mrv, p_mwv;
        logic [N-1:0] p_crr, p_cwr;
        logic [A-1:0] p_mra, p_mwa;
        txn_t         cur;
        p_mrv = 1'b0; p_mwv = 1'b0; p_crr = '0; p_cwr = '0; p_mra = '0; p_mwa = '0;
        cur.wr = 1'b0; cur.c = 0; cur.addr = '0; cur.data = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                p_mrv = 1'b0; p_mwv = 1'b0; p_crr = '0; p_cwr = '0;
            end else begin
                check("mem_valid_exclusive", mrv && mwv, 0);
                check("ready_onehot", $countones({crr, cwr}) <= 1, 1);
                if (mon_en) begin
                    if (mrv && p_mrv) check("rd_addr_stable", mra, p_mra);
                    if (mwv && p_mwv) check("wr_addr_stable", mwa, p_mwa);
                    if ((mrv && !p_mrv) || (mwv && !p_mwv)) begin
                        if (exp_q.size() == 0) begin
                            n_total++;
                            n_bad++;
                            $display("FAIL unexpected_grant: rd=%0b wr=%0b required none", mrv, mwv);
                        end else begin
                            cur = exp_q.pop_front();
                            check("grant_is_write", mwv, cur.wr);
                            if (mrv) check("rd_addr", mra, cur.addr);
                            if (mwv) begin
                                check("wr_addr", mwa, cur.addr);
                                check("wr_data", mwd, cur.data);
                            end
                        end
                    end
                    if (crr != '0 && p_crr == '0) begin
                        check("rd_ready_who", crr, 64'(1) << cur.c);
                        check("rd_data", crd[cur.c*D +: D], cur.data);
                    end
                    if (cwr != '0 && p_cwr == '0) check("wr_ready_who", cwr, 64'(1) << cur.c);
                end
                p_mrv = mrv; p_mwv = mwv; p_crr = crr; p_cwr = cwr; p_mra = mra; p_mwa = mwa;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cyc;
        logic [D-1:0] v;
        for (int a = 0; a < 256; a++) begin
            v           = D'($urandom);
            ref_mem[a]  = v;
            resp_mem[a] = v;
        end
        for (int i = 0; i < N; i++) ref_rdata[i] = '0;
        rand_reqs();

        reset = 1'b0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_mem_valids", {mrv, mwv}, 0);
        check("rst_mem_addr_data", {mra, mwa, mwd}, 0);
        check("rst_ready", {crr, cwr}, 0);
        check("rst_rdata", crd, 0);
        reset = 1'b1;
        tick();

        // Spurious memory ready while idle must be ignored.
        spur = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("spur_busy", busy, 0);
            check("spur_ready", {crr, cwr, mrv, mwv}, 0);
        end
        spur = 1'b0;

        // Consumer 2 loads 0x10, memory answers 0x5A after 3 cycles.
        ref_mem[8'h10]  = 8'h5A;
        resp_mem[8'h10] = 8'h5A;
        req_ra[2] = 8'h10;
        resp_fix  = 3;
        issue(4'b0100, 4'b0000);
        tick();
        check("lat_rd_valid", mrv, 1);
        check("lat_rd_addr", mra, 8'h10);
        wait_idle("single_read");
        resp_fix = -1;

        // Pointer now at 3: all four loads are served 3,0,1,2.
        rand_reqs();
        issue(4'b1111, 4'b0000);
        wait_idle("all_reads_rr3");

        // Load and store from one consumer: load first, store on a later grant.
        rand_reqs();
        req_ra[1] = 8'h20;
        req_wa[1] = 8'h21;
        req_wd[1] = 8'h33;
        issue(4'b0010, 4'b0010);
        wait_idle("read_then_write");

        // Consumer 0 withdraws during the memory wait; the load still completes.
        rand_reqs();
        resp_hold = 1'b1;
        issue(4'b0001, 4'b0000);
        cyc = 0;
        while (!mrv && cyc < 20) begin tick(); cyc++; end
        check("drop_rd_started", mrv, 1);
        rv = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("drop_rd_valid_held", mrv, 1);
        end
        resp_hold = 1'b0;
        cyc = 0;
        while (!crr[0] && cyc < 20) begin tick(); cyc++; end
        check("drop_rd_ready", crr[0], 1);
        tick();
        check("drop_relay_exit_ready", crr, 0);
        check("drop_relay_exit_busy", busy, 0);
        wait_idle("drop_during_wait");

        for (int b = 0; b < 40; b++) begin
            rand_reqs();
            issue(N'($urandom), N'($urandom));
            wait_idle("random_batch");
        end

        // Reset in the middle of a store abandons it.
        mon_en    = 1'b0;
        resp_hold = 1'b1;
        wa[2*A +: A] = 8'h44;
        wd[2*D +: D] = 8'h99;
        wv = 4'b0100;
        cyc = 0;
        while (!mwv && cyc < 20) begin tick(); cyc++; end
        check("rst_wr_started", mwv, 1);
        tick();
        reset = 1'b0;
        wv    = '0;
        tick();
        check("rst_wr_valid", mwv, 0);
        check("rst_wr_busy", busy, 0);
        check("rst_wr_ready", {crr, cwr}, 0);
        check("rst_wr_rdata", crd, 0);
        reset     = 1'b1;
        resp_hold = 1'b0;
        m_rr      = 0;
        for (int i = 0; i < N; i++) ref_rdata[i] = '0;
        tick();
        mon_en = 1'b1;

        // Pointer back at 0: two rounds of 0,1,2,3.
        for (int r = 0; r < 2; r++) begin
            rand_reqs();
            issue(4'b1111, 4'b0000);
            wait_idle("all_reads_after_reset");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
